mandelbrot_ctr_reader: RTL
==========================

// Module: mandelbrot_ctr_reader
// PURPOSE
//   Host-side reader for the Mandelbrot core's nibble-muxed result interface.
//   On each new_ctr pulse it steps ctr_select over all nibbles, waits for the pins to settle,
//   and reassembles the CTRWIDTH-bit iteration count.
//   Tags each count with its pixel (x,y) and frame-end flag, then queues it in a small FIFO
//   behind a valid/ready stream.
// PARAMETERS
//   CTRWIDTH    7   iteration counter width; NIBBLES = ceil(CTRWIDTH/4) (localparam, 1..4)
//   SETTLE      2   cycles ctr_select is held before ctr_nibble is sampled (>=1)
//   IMG_W       80  pixels per line;  XW = 7 bits of x coordinate
//   IMG_H       60  lines per frame;  YW = 6 bits of y coordinate
//   FIFO_DEPTH  2   output queue entries (power of two, >=2)
// PORTS
//   clk          in   1         clock
//   reset        in   1         synchronous, active-high reset
//   ctr_nibble   in   4         nibble from core, = ctr[4*sel+3 : 4*sel], zero-padded above CTRWIDTH
//   new_ctr      in   1         core strobe: new count available (rising edge significant)
//   ctr_select   out  2         nibble select driven to core
//   pix_valid    out  1         FIFO head valid
//   pix_ready    in   1         consumer accepts head when pix_valid & pix_ready
//   pix_ctr      out  CTRWIDTH  reassembled iteration count
//   pix_x        out  XW        pixel column
//   pix_y        out  YW        pixel line
//   pix_last     out  1         1 on pixel (IMG_W-1, IMG_H-1)
//   busy         out  1         FSM not in IDLE
//   overrun      out  1         sticky: a new_ctr edge was dropped
//   clr_overrun  in   1         clears overrun
// BEHAVIOUR
//   Reset: FSM=IDLE, ctr_select=0, x=y=0, FIFO empty, pix_valid=0, overrun=0, busy=0.
//     Reset mid-operation discards the partial count and all queued pixels.
//   new_ctr is registered once. An edge is registered-high while the previous sample was low.
//   FSM states:
//     IDLE: on edge -> SEL with k=0, ctr_select=0, settle=SETTLE.
//     SEL: settle decrements each cycle. At 0, asm[4k+:4] <= ctr_nibble.
//       If k==NIBBLES-1 -> PUSH; else k++, ctr_select=k, settle=SETTLE.
//     PUSH: if FIFO can accept (not full, or full with a pop this cycle), write {asm,x,y,last},
//       advance coordinates, -> IDLE. Otherwise stay in PUSH (stall).
//   Latency: edge sample to pix_valid = 1 + NIBBLES*(SETTLE+1) + 2 cycles (9 for defaults),
//     provided the FIFO is not full.
//   Width rule: bits of the top nibble at positions >= CTRWIDTH are discarded.
//   Coordinates: x wraps IMG_W-1 -> 0 and increments y. y wraps IMG_H-1 -> 0.
//     last=1 only on the final pixel. Coordinates advance only on a successful push.
//   Overrun: an edge seen while FSM != IDLE (SEL or PUSH stall) sets overrun.
//     The dropped event does not advance coordinates.
//     If set and clr_overrun occur in the same cycle, set wins.
//   ctr_select returns to 0 in IDLE.
//   FIFO: head is registered on the outputs. pix_* are stable while pix_valid & !pix_ready.
//     Simultaneous push and pop on a full FIFO is allowed. Push on an empty FIFO becomes
//     visible the next cycle (no bypass).
// STRUCTURE
//   mandelbrot_pkg: NIBBLE_W=4, SEL_W=2, reader_state_t enum {IDLE,SEL,PUSH},
//     function nibbles(ctrwidth).
//   Sub-module pixel_fifo (sync FIFO, WIDTH=CTRWIDTH+XW+YW+1, DEPTH=FIFO_DEPTH,
//     full/empty, registered head).
//   Top holds the edge detector, FSM, settle/nibble counters, assembly register,
//     x/y counters and overrun flag.
// TESTING
//   1 Core model, ctr=0x5A, single new_ctr pulse, pix_ready=1
//     -> select sequence 0,0,0,1,1,1; pix_ctr=0x5A, x=0, y=0, pix_valid exactly 9 cycles after edge.
//   2 ctr=0x7F then 0x00 -> top-nibble bit 3 ignored; counts 0x7F, 0x00 emitted in order,
//     x=0 then 1.
//   3 Stream IMG_W*IMG_H+1 pulses, 12 cycles apart
//     -> pix_last only on (79,59); next pixel (0,0); no overrun.
//   4 pix_ready=0, 4 spaced pulses -> 2 queued, 3rd stalls in PUSH, 4th sets overrun;
//     release ready -> counts 1,2,3 out with x=0,1,2.
//   5 Second new_ctr edge 3 cycles after the first -> overrun=1, single pixel out;
//     clr_overrun together with a new overrun -> stays 1.
//   6 Assert reset during SEL with a queued pixel -> next cycle pix_valid=0, ctr_select=0,
//     busy=0, x=y=0.

Source files
------------

// File: rtl/mandelbrot_pkg.sv
// ============================================================================
// Module : mandelbrot_pkg
// Brief  : Shared widths, reader FSM states and helpers for the result reader.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mandelbrot_pkg;

   localparam int NIBBLE_W = 4;
   localparam int SEL_W    = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEL  = 2'd1,
      PUSH = 2'd2
   } reader_state_t;

   function automatic int nibbles(input int ctrwidth);
      return (ctrwidth + NIBBLE_W - 1) / NIBBLE_W;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mandelbrot_ctr_reader_fifo.sv
// ============================================================================
// Module : pixel_fifo
// Brief  : Synchronous FIFO with a registered head; writes show up one cycle later.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_fifo #(
   parameter int WIDTH = 14,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             accept_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] data_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             full, pop, wr;

   assign full     = (count_q == CW'(DEPTH));
   assign pop      = valid_q & ready_i;
   assign accept_o = ~full | pop;
   assign wr       = push_i & accept_o;
   assign valid_o  = valid_q;
   assign data_o   = head_q;

   // Head is refilled only from entries that were already stored, so a push
   // into an empty queue is not bypassed to the outputs.
   always_comb begin
      wptr_d  = wptr_q + AW'(wr);
      rptr_d  = rptr_q + AW'(pop);
      count_d = count_q + CW'(wr) - CW'(pop);
      valid_d = (count_q - CW'(pop)) != '0;
      head_d  = valid_d ? mem_q[rptr_d] : head_q;
   end

   always_ff @(posedge clk) begin
      if (wr) begin
         mem_q[wptr_q] <= data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
         head_q  <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         valid_q <= valid_d;
         head_q  <= head_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mandelbrot_ctr_reader.sv
// ============================================================================
// Module : mandelbrot_ctr_reader
// Brief  : Reassembles nibble-muxed iteration counts, tags them with (x,y,last)
//          and queues them behind a valid/ready stream.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mandelbrot_ctr_reader
   import mandelbrot_pkg::*;
#(
   parameter  int CTRWIDTH   = 7,
   parameter  int SETTLE     = 2,
   parameter  int IMG_W      = 80,
   parameter  int IMG_H      = 60,
   parameter  int FIFO_DEPTH = 2,
   localparam int XW         = $clog2(IMG_W),
   localparam int YW         = $clog2(IMG_H)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [3:0]          ctr_nibble,
   input  logic                new_ctr,
   output logic [SEL_W-1:0]    ctr_select,
   output logic                pix_valid,
   input  logic                pix_ready,
   output logic [CTRWIDTH-1:0] pix_ctr,
   output logic [XW-1:0]       pix_x,
   output logic [YW-1:0]       pix_y,
   output logic                pix_last,
   output logic                busy,
   output logic                overrun,
   input  logic                clr_overrun
);

   localparam int NIBBLES = nibbles(CTRWIDTH);
   localparam int SW      = $clog2(SETTLE + 1);
   localparam int FW      = CTRWIDTH + XW + YW + 1;

   reader_state_t       state_q, state_d;
   logic                new_q, prev_q;
   logic [SEL_W-1:0]    k_q, k_d;
   logic [SW-1:0]       settle_q, settle_d;
   logic [CTRWIDTH-1:0] asm_q, asm_d;
   logic [XW-1:0]       x_q, x_d;
   logic [YW-1:0]       y_q, y_d;
   logic                overrun_q, overrun_d;
   logic                edge_det, push, accept, x_end, y_end;
   logic [FW-1:0]       fifo_out;

   assign edge_det   = new_q & ~prev_q;
   assign x_end      = (x_q == XW'(IMG_W - 1));
   assign y_end      = (y_q == YW'(IMG_H - 1));
   assign ctr_select = k_q;
   assign busy       = (state_q != IDLE);
   assign overrun    = overrun_q;

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      settle_d  = settle_q;
      asm_d     = asm_q;
      x_d       = x_q;
      y_d       = y_q;
      overrun_d = overrun_q;
      push      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (edge_det) begin
               state_d  = SEL;
               k_d      = '0;
               settle_d = SW'(SETTLE);
            end
         end
         SEL: begin
            if (settle_q != '0) begin
               settle_d = settle_q - SW'(1);
            end else begin
               // Bits of the top nibble beyond CTRWIDTH simply have no home.
               for (int b = 0; b < CTRWIDTH; b++) begin
                  if (b / NIBBLE_W == int'(k_q)) begin
                     asm_d[b] = ctr_nibble[b % NIBBLE_W];
                  end
               end
               if (k_q == SEL_W'(NIBBLES - 1)) begin
                  state_d = PUSH;
               end else begin
                  k_d      = k_q + SEL_W'(1);
                  settle_d = SW'(SETTLE);
               end
            end
         end
         PUSH: begin
            if (accept) begin
               push    = 1'b1;
               k_d     = '0;
               state_d = IDLE;
               if (x_end) begin
                  x_d = '0;
                  y_d = y_end ? '0 : y_q + YW'(1);
               end else begin
                  x_d = x_q + XW'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            k_d     = '0;
         end
      endcase

      if (edge_det && state_q != IDLE) begin
         overrun_d = 1'b1;
      end else if (clr_overrun) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         new_q     <= 1'b0;
         prev_q    <= 1'b0;
         k_q       <= '0;
         settle_q  <= '0;
         asm_q     <= '0;
         x_q       <= '0;
         y_q       <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         new_q     <= new_ctr;
         prev_q    <= new_q;
         k_q       <= k_d;
         settle_q  <= settle_d;
         asm_q     <= asm_d;
         x_q       <= x_d;
         y_q       <= y_d;
         overrun_q <= overrun_d;
      end
   end

   pixel_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push_i   (push),
      .data_i   ({asm_q, x_q, y_q, x_end & y_end}),
      .accept_o (accept),
      .valid_o  (pix_valid),
      .ready_i  (pix_ready),
      .data_o   (fifo_out)
   );

   assign {pix_ctr, pix_x, pix_y, pix_last} = fifo_out;

endmodule

`default_nettype wire
